// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared word type and memory-access FSM state encoding
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IND    = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } mau_state_t;

    function automatic lc3b_word word_align(input lc3b_word a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - byte-lane steering: enables, store replication, load extraction
import lc3b_types::*;

module mem_byte_lane (
    input  logic       byte_mode,
    input  logic       addr_lsb,
    input  lc3b_word   wdata,
    input  lc3b_word   mem_rdata,
    output logic [1:0] byte_enable,
    output lc3b_word   mem_wdata,
    output lc3b_word   rdata
);

    always_comb begin
        byte_enable = 2'b11;
        mem_wdata   = wdata;
        rdata       = mem_rdata;
        if (byte_mode) begin
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
            mem_wdata   = {wdata[7:0], wdata[7:0]};
            rdata       = addr_lsb ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage sequencer for direct/indirect word and byte accesses
import lc3b_types::*;

module mem_access_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic       read,
    input  logic       write,
    input  logic       indirect,
    input  logic       mem_byte_sig,
    input  lc3b_word   addr,
    input  lc3b_word   wdata,
    output logic       stall,
    output logic       done,
    output lc3b_word   rdata,
    output logic       dmem_read,
    output logic       dmem_write,
    output lc3b_word   dmem_address,
    output lc3b_word   dmem_wdata,
    output logic [1:0] dmem_byte_enable,
    input  lc3b_word   dmem_rdata,
    input  logic       dmem_resp
);

    mau_state_t state, next_state;

    logic     lat_read, lat_write, lat_ind, lat_byte;
    lc3b_word lat_addr, lat_wdata, pointer, rdata_q;
    lc3b_word eff_addr, lane_wdata, lane_rdata;
    logic [1:0] lane_be;
    logic     request;

    assign request  = valid_in & (read | write);
    assign eff_addr = lat_ind ? pointer : lat_addr;
    assign rdata    = rdata_q;

    mem_byte_lane u_lane (
        .byte_mode   (lat_byte),
        .addr_lsb    (eff_addr[0]),
        .wdata       (lat_wdata),
        .mem_rdata   (dmem_rdata),
        .byte_enable (lane_be),
        .mem_wdata   (lane_wdata),
        .rdata       (lane_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_ind   <= 1'b0;
            lat_byte  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            pointer   <= '0;
            rdata_q   <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: if (request) begin
                    // a simultaneous write request is dropped in favour of the read
                    lat_read  <= read;
                    lat_write <= write & ~read;
                    lat_ind   <= indirect;
                    lat_byte  <= mem_byte_sig;
                    lat_addr  <= addr;
                    lat_wdata <= wdata;
                end
                S_IND:    if (dmem_resp) pointer <= dmem_rdata;
                S_ACCESS: if (dmem_resp && lat_read) rdata_q <= lane_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state       = state;
        stall            = 1'b0;
        done             = 1'b0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = 2'b00;
        case (state)
            S_IDLE: if (request) begin
                stall      = 1'b1;
                next_state = indirect ? S_IND : S_ACCESS;
            end
            S_IND: begin
                // pointer fetch is always a full aligned word
                stall            = 1'b1;
                dmem_read        = 1'b1;
                dmem_address     = word_align(lat_addr);
                dmem_byte_enable = 2'b11;
                if (dmem_resp) next_state = S_ACCESS;
            end
            S_ACCESS: begin
                stall            = 1'b1;
                dmem_read        = lat_read;
                dmem_write       = lat_write;
                dmem_address     = word_align(eff_addr);
                dmem_byte_enable = lane_be;
                dmem_wdata       = lane_wdata;
                if (dmem_resp) next_state = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven scoreboard bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0, read = 1'b0, write = 1'b0, indirect = 1'b0, mem_byte_sig = 1'b0;
    logic [15:0] addr = '0, wdata = '0;
    logic        stall, done;
    logic [15:0] rdata;
    logic        dmem_read, dmem_write;
    logic [15:0] dmem_address, dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_resp = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .read             (read),
        .write            (write),
        .indirect         (indirect),
        .mem_byte_sig     (mem_byte_sig),
        .addr             (addr),
        .wdata            (wdata),
        .stall            (stall),
        .done             (done),
        .rdata            (rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } txn_t;

    typedef struct {
        logic        rd, wr, ind, byt;
        logic [15:0] addr, wdata, ptr, mrdata;
        int          lat;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [1:0]  exp_be;
        logic [15:0] exp_wdata, exp_rdata;
        int          exp_nr, exp_nw, exp_done;
    } vec_t;

    txn_t        exp_q[$];
    logic [15:0] resp_q[$];
    txn_t        sb_t;
    vec_t        vecs[9];

    int tests = 0, fails = 0;
    int lat_cfg = 1, wait_cnt = 0, n_rd = 0, n_wr = 0;
    bit force_resp = 1'b0;
    logic [15:0] force_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: answers each strobe after lat_cfg strobe cycles and scores the transaction.
    always @(negedge clk) begin
        check("rw_exclusive", {31'b0, dmem_read & dmem_write}, 32'd0);
        if (force_resp) begin
            dmem_resp  = 1'b1;
            dmem_rdata = force_data;
        end else if (dmem_read | dmem_write) begin
            wait_cnt++;
            if (wait_cnt >= lat_cfg) begin
                wait_cnt   = 0;
                dmem_resp  = 1'b1;
                dmem_rdata = (resp_q.size() > 0) ? resp_q.pop_front() : 16'h0000;
                if (dmem_read) n_rd++;
                if (dmem_write) n_wr++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got txn at %h expected none", dmem_address);
                end else begin
                    sb_t = exp_q.pop_front();
                    check("sb_dir", {31'b0, dmem_write}, {31'b0, sb_t.wr});
                    check("sb_addr", {16'b0, dmem_address}, {16'b0, sb_t.addr});
                    check("sb_be", {30'b0, dmem_byte_enable}, {30'b0, sb_t.be});
                    if (sb_t.wr) check("sb_wdata", {16'b0, dmem_wdata}, {16'b0, sb_t.wdata});
                end
            end else begin
                dmem_resp = 1'b0;
            end
        end else begin
            dmem_resp = 1'b0;
            wait_cnt  = 0;
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        txn_t t;
        bit   seen;
        n_rd = 0;
        n_wr = 0;
        lat_cfg = v.lat;
        if (v.ind) begin
            t.wr = 1'b0; t.addr = v.addr & 16'hFFFE; t.be = 2'b11; t.wdata = '0;
            exp_q.push_back(t);
            resp_q.push_back(v.ptr);
        end
        t.wr = v.exp_wr; t.addr = v.exp_addr; t.be = v.exp_be; t.wdata = v.exp_wdata;
        exp_q.push_back(t);
        resp_q.push_back(v.mrdata);

        @(posedge clk); #1;
        valid_in = 1'b1; read = v.rd; write = v.wr; indirect = v.ind; mem_byte_sig = v.byt;
        addr = v.addr; wdata = v.wdata;
        seen = 1'b0;
        for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check($sformatf("v%0d_done_cycle", idx), cyc, v.exp_done);
                check($sformatf("v%0d_done_stall", idx), {31'b0, stall}, 32'd0);
                check($sformatf("v%0d_rdata", idx), {16'b0, rdata}, {16'b0, v.exp_rdata});
            end else if (cyc < v.exp_done) begin
                check($sformatf("v%0d_stall", idx), {31'b0, stall}, 32'd1);
            end
            if (cyc == 0) begin
                check($sformatf("v%0d_accept_no_strobe", idx), {30'b0, dmem_read, dmem_write}, 32'd0);
                @(posedge clk); #1;
                // scramble request inputs: the unit must work from its latched copy
                valid_in = 1'b0; read = 1'b1; write = 1'b1; indirect = 1'b0; mem_byte_sig = 1'b0;
                addr = 16'hFFFF; wdata = 16'hFFFF;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL v%0d_done_timeout: got no done expected done at cycle %0d", idx, v.exp_done);
        end
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", idx), {30'b0, done, stall}, 32'd0);
        check($sformatf("v%0d_reads", idx), n_rd, v.exp_nr);
        check($sformatf("v%0d_writes", idx), n_wr, v.exp_nw);
        check($sformatf("v%0d_sb_empty", idx), exp_q.size(), 0);
        exp_q.delete();
        resp_q.delete();
    endtask

    initial begin
        bit bad;
        vecs[0] = '{1,0,0,0, 16'h1235, 16'h0000, 16'h0000, 16'hBEEF, 3, 0, 16'h1234, 2'b11, 16'h0000, 16'hBEEF, 1, 0, 4};
        vecs[1] = '{0,1,0,1, 16'h2001, 16'h00A5, 16'h0000, 16'h0000, 2, 1, 16'h2000, 2'b10, 16'hA5A5, 16'hBEEF, 0, 1, 3};
        vecs[2] = '{1,0,1,0, 16'h3000, 16'h0000, 16'h4003, 16'h7777, 1, 0, 16'h4002, 2'b11, 16'h0000, 16'h7777, 2, 0, 3};
        vecs[3] = '{0,1,1,1, 16'h6000, 16'h1234, 16'h5001, 16'h0000, 2, 1, 16'h5000, 2'b10, 16'h3434, 16'h7777, 1, 1, 5};
        vecs[4] = '{1,1,0,0, 16'h0100, 16'hDEAD, 16'h0000, 16'h1111, 1, 0, 16'h0100, 2'b11, 16'h0000, 16'h1111, 1, 0, 2};
        vecs[5] = '{1,0,0,1, 16'h0A10, 16'h0000, 16'h0000, 16'hAB5C, 2, 0, 16'h0A10, 2'b01, 16'h0000, 16'h005C, 1, 0, 3};
        vecs[6] = '{1,0,0,1, 16'h0A11, 16'h0000, 16'h0000, 16'hAB5C, 2, 0, 16'h0A10, 2'b10, 16'h0000, 16'h00AB, 1, 0, 3};
        vecs[7] = '{0,1,0,0, 16'h7777, 16'h1357, 16'h0000, 16'h0000, 1, 1, 16'h7776, 2'b11, 16'h1357, 16'h00AB, 0, 1, 2};
        vecs[8] = '{1,0,1,1, 16'h3001, 16'h0000, 16'h2221, 16'hC3D4, 1, 0, 16'h2220, 2'b10, 16'h0000, 16'h00C3, 2, 0, 3};

        repeat (2) @(negedge clk);
        check("reset_ctrl", {28'b0, stall, done, dmem_read, dmem_write}, 32'd0);
        check("reset_addr", {16'b0, dmem_address}, 32'd0);
        check("reset_wdata", {16'b0, dmem_wdata}, 32'd0);
        check("reset_be", {30'b0, dmem_byte_enable}, 32'd0);
        check("reset_rdata", {16'b0, rdata}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // idle with no live request, then a spurious response while idle
        @(posedge clk); #1;
        valid_in = 1'b0; read = 1'b1; write = 1'b0; addr = 16'h1111;
        @(negedge clk);
        check("idle_invalid_stall", {29'b0, stall, dmem_read, dmem_write}, 32'd0);
        @(posedge clk); #1;
        valid_in = 1'b1; read = 1'b0; write = 1'b0;
        @(negedge clk);
        check("idle_norw_stall", {29'b0, stall, dmem_read, dmem_write}, 32'd0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        force_data = 16'h9999;
        force_resp = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_resp_ignored", {28'b0, stall, done, dmem_read, dmem_write}, 32'd0);
        end
        @(posedge clk); #1;
        force_resp = 1'b0;
        @(negedge clk);
        check("idle_resp_rdata_held", {16'b0, rdata}, 32'h00C3);

        // reset while an access is outstanding
        lat_cfg = 1000;
        @(posedge clk); #1;
        valid_in = 1'b1; read = 1'b1; write = 1'b0; indirect = 1'b0; mem_byte_sig = 1'b0; addr = 16'h0456;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        check("mid_access_strobe", {31'b0, dmem_read}, 32'd1);
        check("mid_access_addr", {16'b0, dmem_address}, 32'h0456);
        #2 rst_n = 1'b0;
        #1;
        check("rst_strobe_drop", {28'b0, stall, done, dmem_read, dmem_write}, 32'd0);
        check("rst_addr_be", {14'b0, dmem_address, dmem_byte_enable}, 32'd0);
        check("rst_rdata", {16'b0, rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat_cfg = 1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done | dmem_read | dmem_write | stall) bad = 1'b1;
        end
        check("post_reset_quiet", {31'b0, bad}, 32'd0);
        exp_q.delete();
        resp_q.delete();

        run_vec(vecs[0], 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
